known_ch_table: RTL and testbench

KNOWN_CH_TABLE -- requirements
Module: known_ch_table

---
 rtl/known_ch_table.sv | 156 +++++++++++++++
 tb/tb_known_ch_table.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/known_ch_table.sv
// Cluster-head table: collects CH advertisements for the current heartbeat round
// and, after each advertisement, scans the table to select the best cluster head.
module known_ch_table #(
  parameter int WORD_WIDTH = 16,
  parameter int CH_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_KCH,
  input  logic                        HB_reset,
  input  logic [WORD_WIDTH-1:0]       HB_CHlimit,
  input  logic [WORD_WIDTH-1:0]       fCH_ID,
  input  logic [WORD_WIDTH-1:0]       fCH_Hops,
  input  logic [WORD_WIDTH-1:0]       fCH_QValue,
  output logic                        kch_ready,
  output logic [WORD_WIDTH-1:0]       chosenCH,
  output logic [WORD_WIDTH-1:0]       hopsfromCH,
  output logic [WORD_WIDTH-1:0]       chosenQValue,
  output logic                        choice_valid,
  output logic [$clog2(CH_DEPTH):0]   ch_count,
  output logic                        table_full,
  output logic [1:0]                  fsm_state
);

  // Handshake: an advertisement on fCH_* is taken on a rising edge where
  // en_KCH=1 and kch_ready=1; en_KCH while kch_ready=0 is dropped, not queued.

  localparam int IW = $clog2(CH_DEPTH);
  localparam int CW = IW + 1;
  localparam logic [WORD_WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {IDLE, UPDATE, SCAN, DONE} state_t;

  state_t state, state_nxt;

  logic [WORD_WIDTH-1:0] id_mem  [CH_DEPTH];
  logic [WORD_WIDTH-1:0] hop_mem [CH_DEPTH];
  logic [WORD_WIDTH-1:0] q_mem   [CH_DEPTH];

  logic [WORD_WIDTH-1:0] adv_id, adv_hops, adv_q;
  logic [CW-1:0]         limit, lim_in;
  logic [IW-1:0]         scan_idx;
  logic                  best_valid;
  logic [WORD_WIDTH-1:0] best_id, best_hops, best_q;

  logic                  hit;
  logic [IW-1:0]         hit_idx;
  logic                  mem_we;
  logic [IW-1:0]         mem_idx;
  logic [WORD_WIDTH-1:0] cur_id, cur_hops, cur_q;
  logic                  better, scan_last;

  assign kch_ready  = (state == IDLE);
  assign table_full = (ch_count == limit);
  assign fsm_state  = state;

  assign lim_in = (HB_CHlimit >= WORD_WIDTH'(CH_DEPTH)) ? CW'(CH_DEPTH)
                                                         : HB_CHlimit[CW-1:0];

  // First stored entry whose ID equals the latched advertisement.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < CH_DEPTH; i++) begin
      if (!hit && (CW'(i) < ch_count) && (id_mem[i] == adv_id)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign mem_we  = (state == UPDATE) && !rst && !HB_reset && (hit || (ch_count < limit));
  assign mem_idx = hit ? hit_idx : ch_count[IW-1:0];

  assign cur_id    = id_mem[scan_idx];
  assign cur_hops  = hop_mem[scan_idx];
  assign cur_q     = q_mem[scan_idx];
  // Strict comparison keeps the earlier index on a full tie.
  assign better    = !best_valid || (cur_q > best_q) ||
                     ((cur_q == best_q) && (cur_hops < best_hops));
  assign scan_last = (ch_count == '0) || ({1'b0, scan_idx} == (ch_count - 1'b1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en_KCH) state_nxt = UPDATE;
      UPDATE:  state_nxt = SCAN;
      SCAN:    if (scan_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (HB_reset) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      id_mem[mem_idx]  <= adv_id;
      hop_mem[mem_idx] <= adv_hops;
      q_mem[mem_idx]   <= adv_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || HB_reset) begin
      state        <= IDLE;
      ch_count     <= '0;
      limit        <= rst ? '0 : lim_in;
      chosenCH     <= ALL_ONES;
      hopsfromCH   <= ALL_ONES;
      chosenQValue <= '0;
      choice_valid <= 1'b0;
      scan_idx     <= '0;
      best_valid   <= 1'b0;
    end else begin
      state        <= state_nxt;
      choice_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (en_KCH) begin
            adv_id   <= fCH_ID;
            adv_hops <= fCH_Hops;
            adv_q    <= fCH_QValue;
          end
        end
        UPDATE: begin
          if (!hit && (ch_count < limit)) ch_count <= ch_count + 1'b1;
          scan_idx   <= '0;
          best_valid <= 1'b0;
        end
        SCAN: begin
          if ((ch_count != '0) && better) begin
            best_valid <= 1'b1;
            best_id    <= cur_id;
            best_hops  <= cur_hops;
            best_q     <= cur_q;
          end
          if (!scan_last) scan_idx <= scan_idx + 1'b1;
        end
        DONE: begin
          choice_valid <= 1'b1;
          if (best_valid) begin
            chosenCH     <= best_id;
            hopsfromCH   <= (best_hops == ALL_ONES) ? ALL_ONES : best_hops + 1'b1;
            chosenQValue <= best_q;
          end else begin
            chosenCH     <= ALL_ONES;
            hopsfromCH   <= ALL_ONES;
            chosenQValue <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_known_ch_table.sv
// Directed bench for known_ch_table: expected selections are queued by the
// driver and compared by a monitor whenever choice_valid is seen.
module tb_known_ch_table;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en_KCH = 1'b0;
  logic         HB_reset = 1'b0;
  logic [W-1:0] HB_CHlimit = '0;
  logic [W-1:0] fCH_ID = '0, fCH_Hops = '0, fCH_QValue = '0;
  logic         kch_ready;
  logic [W-1:0] chosenCH, hopsfromCH, chosenQValue;
  logic         choice_valid;
  logic [3:0]   ch_count;
  logic         table_full;
  logic [1:0]   fsm_state;

  int checks = 0;
  int errors = 0;
  logic [3*W-1:0] exp_q[$];

  known_ch_table #(.WORD_WIDTH(W), .CH_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .en_KCH(en_KCH), .HB_reset(HB_reset),
    .HB_CHlimit(HB_CHlimit), .fCH_ID(fCH_ID), .fCH_Hops(fCH_Hops),
    .fCH_QValue(fCH_QValue), .kch_ready(kch_ready), .chosenCH(chosenCH),
    .hopsfromCH(hopsfromCH), .chosenQValue(chosenQValue),
    .choice_valid(choice_valid), .ch_count(ch_count), .table_full(table_full),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [3*W-1:0] e;
    if (choice_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_choice_valid actual=1 expected=0 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("chosenCH", 32'(chosenCH), 32'(e[3*W-1:2*W]));
        chk("hopsfromCH", 32'(hopsfromCH), 32'(e[2*W-1:W]));
        chk("chosenQValue", 32'(chosenQValue), 32'(e[W-1:0]));
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [W-1:0] id, input logic [W-1:0] h, input logic [W-1:0] q);
    int guard = 0;
    @(posedge clk); #1;
    while (!kch_ready && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 40) chk("ready_timeout", 32'(kch_ready), 32'd1);
    en_KCH = 1'b1; fCH_ID = id; fCH_Hops = h; fCH_QValue = q;
    @(posedge clk); #1;
    en_KCH = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input int start,
                           input int exp_cnt, input logic exp_full);
    int cyc = start;
    bit got = 0;
    while (!got && cyc < 40) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (choice_valid === 1'b1) got = 1;
    end
    chk({name, "_latency"}, got ? 32'(cyc) : 32'hDEAD, 32'(exp_lat));
    chk({name, "_count"}, 32'(ch_count), 32'(exp_cnt));
    chk({name, "_full"}, 32'(table_full), 32'(exp_full));
  endtask

  task automatic send(input string name, input logic [W-1:0] id, input logic [W-1:0] h,
                      input logic [W-1:0] q, input logic [W-1:0] e_id,
                      input logic [W-1:0] e_h, input logic [W-1:0] e_q,
                      input int e_cnt, input logic e_full);
    exp_q.push_back({e_id, e_h, e_q});
    issue(id, h, q);
    wait_done(name, ((e_cnt < 1) ? 1 : e_cnt) + 2, 0, e_cnt, e_full);
  endtask

  task automatic hb(input logic [W-1:0] lim);
    @(posedge clk); #1;
    HB_reset = 1'b1; HB_CHlimit = lim;
    @(posedge clk); #1;
    HB_reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_chosenCH", 32'(chosenCH), 32'hFFFF);
    chk("rst_hops", 32'(hopsfromCH), 32'hFFFF);
    chk("rst_q", 32'(chosenQValue), 32'd0);
    chk("rst_valid", 32'(choice_valid), 32'd0);
    chk("rst_ready", 32'(kch_ready), 32'd1);
    chk("rst_full", 32'(table_full), 32'd1);
    chk("rst_count", 32'(ch_count), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'd0);

    // limit 10 clamps to depth 8
    hb(16'd10);
    @(negedge clk);
    chk("hb10_full", 32'(table_full), 32'd0);
    chk("hb10_count", 32'(ch_count), 32'd0);

    send("first",  16'd3, 16'd2, 16'd50, 16'd3, 16'd3, 16'd50, 1, 1'b0);
    send("second", 16'd5, 16'd4, 16'd80, 16'd5, 16'd5, 16'd80, 2, 1'b0);
    send("tie_hops", 16'd7, 16'd1, 16'd80, 16'd7, 16'd2, 16'd80, 3, 1'b0);
    send("overwrite", 16'd7, 16'd9, 16'd10, 16'd5, 16'd5, 16'd80, 3, 1'b0);
    send("tie_index", 16'd8, 16'd4, 16'd80, 16'd5, 16'd5, 16'd80, 4, 1'b0);

    // en_KCH pulsed during SCAN must be dropped
    exp_q.push_back({16'd9, 16'd1, 16'd200});
    issue(16'd9, 16'd0, 16'd200);
    @(posedge clk); #1;
    en_KCH = 1'b1; fCH_ID = 16'd11; fCH_Hops = 16'd0; fCH_QValue = 16'd300;
    @(posedge clk); #1;
    en_KCH = 1'b0;
    wait_done("ignored_en", 7, 2, 5, 1'b0);
    repeat (6) @(negedge clk);
    chk("ignored_en_count_after", 32'(ch_count), 32'd5);

    // limit 2: third distinct ID dropped
    hb(16'd2);
    @(negedge clk);
    chk("hb2_count", 32'(ch_count), 32'd0);
    chk("hb2_chosenCH", 32'(chosenCH), 32'hFFFF);
    send("lim_a", 16'd1, 16'd3, 16'd20, 16'd1, 16'd4, 16'd20, 1, 1'b0);
    send("lim_b", 16'd2, 16'd3, 16'd20, 16'd1, 16'd4, 16'd20, 2, 1'b1);
    send("lim_drop", 16'd4, 16'd0, 16'd99, 16'd1, 16'd4, 16'd20, 2, 1'b1);

    // HB_reset coincident with en_KCH wins
    @(posedge clk); #1;
    HB_reset = 1'b1; HB_CHlimit = 16'd8;
    en_KCH = 1'b1; fCH_ID = 16'd6; fCH_Hops = 16'd1; fCH_QValue = 16'd7;
    @(posedge clk); #1;
    HB_reset = 1'b0; en_KCH = 1'b0;
    repeat (8) @(negedge clk);
    chk("hb_en_count", 32'(ch_count), 32'd0);
    chk("hb_en_chosenCH", 32'(chosenCH), 32'hFFFF);
    chk("hb_en_hops", 32'(hopsfromCH), 32'hFFFF);
    chk("hb_en_q", 32'(chosenQValue), 32'd0);
    chk("hb_en_ready", 32'(kch_ready), 32'd1);

    send("hops_sat", 16'd6, 16'hFFFF, 16'd5, 16'd6, 16'hFFFF, 16'd5, 1, 1'b0);

    // limit 0: nothing accepted, empty selection still pulses
    hb(16'd0);
    @(negedge clk);
    chk("hb0_full", 32'(table_full), 32'd1);
    send("lim0", 16'd12, 16'd1, 16'd1, 16'hFFFF, 16'hFFFF, 16'd0, 0, 1'b1);

    // rst mid-SCAN aborts without a pulse
    hb(16'd8);
    send("pre_rst", 16'd20, 16'd1, 16'd1, 16'd20, 16'd2, 16'd1, 1, 1'b0);
    issue(16'd21, 16'd2, 16'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_scan_count", 32'(ch_count), 32'd0);
    chk("rst_scan_full", 32'(table_full), 32'd1);
    chk("rst_scan_chosenCH", 32'(chosenCH), 32'hFFFF);
    chk("rst_scan_ready", 32'(kch_ready), 32'd1);

    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
